// File: rtl/rv32i_core_pkg.sv
// Shared types for the RV32I decode stage: fetch/decode payloads, the buffered
// ID entry, and the decoder / immediate-generator helpers.
package rv32i_core_pkg;

  // Upper bound on the ID/EX buffer depth, independent of any instance's DEPTH.
  localparam int unsigned ID_PIPE_MAX_DEPTH = 4;
  localparam int unsigned ID_PIPE_PTR_W     = 2;
  localparam int unsigned ID_PIPE_CNT_W     = 3;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic {StRun, StTrap} id_state_e;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
  } id_ex_payload_t;

  typedef struct packed {
    logic     illegal;
    logic     uses_rs1;
    logic     uses_rs2;
    logic     alu_src_imm;
    logic     alu_src_pc;
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     jump;
    imm_sel_e imm_sel;
  } dec_ctrl_t;

  typedef struct packed {
    id_ex_payload_t payload;
    logic           illegal;
    logic [31:0]    instr;
  } id_entry_t;

  function automatic dec_ctrl_t rv32i_decoder(input logic [6:0] opcode, input logic [2:0] funct3);
    dec_ctrl_t d;
    d = '0;
    d.imm_sel = ImmI;
    case (opcode)
      OpLui:    begin d.reg_write = 1'b1; d.alu_src_imm = 1'b1; d.imm_sel = ImmU; end
      OpAuipc:  begin
        d.reg_write = 1'b1; d.alu_src_imm = 1'b1; d.alu_src_pc = 1'b1; d.imm_sel = ImmU;
      end
      OpJal:    begin d.reg_write = 1'b1; d.jump = 1'b1; d.alu_src_pc = 1'b1; d.imm_sel = ImmJ; end
      OpJalr:   begin
        d.reg_write = 1'b1; d.jump = 1'b1; d.uses_rs1 = 1'b1; d.alu_src_imm = 1'b1;
        d.illegal = (funct3 != 3'b000);
      end
      OpBranch: begin d.branch = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.imm_sel = ImmB; end
      OpLoad:   begin
        d.reg_write = 1'b1; d.mem_read = 1'b1; d.uses_rs1 = 1'b1; d.alu_src_imm = 1'b1;
      end
      OpStore:  begin
        d.mem_write = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.alu_src_imm = 1'b1;
        d.imm_sel = ImmS;
      end
      OpImm:    begin d.reg_write = 1'b1; d.uses_rs1 = 1'b1; d.alu_src_imm = 1'b1; end
      OpReg:    begin
        d.reg_write = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.imm_sel = ImmNone;
      end
      // Fence and system decode as no-ops at this stage.
      OpFence, OpSystem: d.imm_sel = ImmI;
      default:  d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [31:0] rv32i_imm_gen(input logic [31:7] i, input imm_sel_e sel);
    logic [31:0] imm;
    case (sel)
      ImmI:    imm = {{20{i[31]}}, i[31:20]};
      ImmS:    imm = {{20{i[31]}}, i[31:25], i[11:7]};
      ImmB:    imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      ImmU:    imm = {i[31:12], 12'b0};
      ImmJ:    imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv32i_id_fifo.sv
// Circular buffer of decoded ID entries with occupancy count. Depth is 1..4;
// storage is always sized for the maximum so pointers index it without casts.
module rv32i_id_fifo
  import rv32i_core_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  id_entry_t                data_i,
  output id_entry_t                head_o,
  output id_entry_t                tail_o,
  output logic [ID_PIPE_CNT_W-1:0] count_o,
  output logic                     full_o
);

  localparam logic [ID_PIPE_PTR_W-1:0] LastIdx = ID_PIPE_PTR_W'(Depth - 1);

  id_entry_t                mem_q [ID_PIPE_MAX_DEPTH];
  id_entry_t                mem_d [ID_PIPE_MAX_DEPTH];
  logic [ID_PIPE_PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, tail_ptr;
  logic [ID_PIPE_CNT_W-1:0] count_q, count_d;

  // Pointer/count update; a flush wins over any push or pop in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + ID_PIPE_PTR_W'(1);
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + ID_PIPE_PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + ID_PIPE_CNT_W'(1);
      2'b01:   count_d = count_q - ID_PIPE_CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State registers; storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ID_PIPE_MAX_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign tail_ptr = (wr_ptr_q == '0) ? LastIdx : wr_ptr_q - ID_PIPE_PTR_W'(1);
  assign head_o   = mem_q[rd_ptr_q];
  assign tail_o   = mem_q[tail_ptr];
  assign count_o  = count_q;
  assign full_o   = (count_q == ID_PIPE_CNT_W'(Depth));

endmodule

// File: rtl/rv32i_id_pipe.sv
// Buffered RV32I decode stage: decodes the fetch word, reads the register file,
// and queues the result toward EX. Illegal words trap (TRAP_ILLEGAL=1) until a
// flush, or are swallowed (TRAP_ILLEGAL=0). Define RV32I_LOAD_USE_STALL_EN to
// stall fetch on load-use hazards.
module rv32i_id_pipe
  import rv32i_core_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter bit          TRAP_ILLEGAL = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           if_valid_i,
  input  if_id_payload_t if_payload_i,
  output logic           if_ready_o,
  output logic           id_valid_o,
  output id_ex_payload_t id_payload_o,
  input  logic           id_ready_i,
  output logic           id_illegal_o,
  output logic [31:0]    id_illegal_instr_o,
  output logic [4:0]     rf_rs1_addr_o,
  output logic [4:0]     rf_rs2_addr_o,
  input  logic [31:0]    rf_rs1_data_i,
  input  logic [31:0]    rf_rs2_data_i,
  input  logic           flush_i,
  input  logic           ex_mem_read_i,
  input  logic [4:0]     ex_rd_addr_i
);

  id_state_e                state_q, state_d;
  dec_ctrl_t                dec;
  id_entry_t                entry_in, head, tail;
  logic [ID_PIPE_CNT_W-1:0] count;
  logic                     full, hazard, push, pop;

  assign rf_rs1_addr_o = if_payload_i.instr[19:15];
  assign rf_rs2_addr_o = if_payload_i.instr[24:20];

  // Decode the fetch word into the entry that would be enqueued this cycle.
  always_comb begin
    dec      = rv32i_decoder(if_payload_i.instr[6:0], if_payload_i.instr[14:12]);
    entry_in = '0;
    entry_in.payload.pc          = if_payload_i.pc;
    entry_in.payload.pc_plus4    = if_payload_i.pc + 32'd4;
    entry_in.payload.rs1_data    = rf_rs1_data_i;
    entry_in.payload.rs2_data    = rf_rs2_data_i;
    entry_in.payload.imm         = rv32i_imm_gen(if_payload_i.instr[31:7], dec.imm_sel);
    entry_in.payload.rs1_addr    = if_payload_i.instr[19:15];
    entry_in.payload.rs2_addr    = if_payload_i.instr[24:20];
    entry_in.payload.rd_addr     = if_payload_i.instr[11:7];
    entry_in.payload.funct3      = if_payload_i.instr[14:12];
    entry_in.payload.funct7_5    = if_payload_i.instr[30];
    entry_in.payload.alu_src_imm = dec.alu_src_imm;
    entry_in.payload.alu_src_pc  = dec.alu_src_pc;
    // Side-effecting controls never leave ID for an illegal word.
    entry_in.payload.reg_write   = dec.reg_write & ~dec.illegal;
    entry_in.payload.mem_read    = dec.mem_read  & ~dec.illegal;
    entry_in.payload.mem_write   = dec.mem_write & ~dec.illegal;
    entry_in.payload.branch      = dec.branch    & ~dec.illegal;
    entry_in.payload.jump        = dec.jump      & ~dec.illegal;
    entry_in.illegal             = dec.illegal;
    entry_in.instr               = if_payload_i.instr;
  end

`ifdef RV32I_LOAD_USE_STALL_EN
  // Stall a consumer of a load result still in EX or the newest buffered entry.
  always_comb begin
    hazard = 1'b0;
    if (dec.uses_rs1 && (rf_rs1_addr_o != 5'd0)) begin
      if (ex_mem_read_i && (ex_rd_addr_i == rf_rs1_addr_o)) hazard = 1'b1;
      if (id_valid_o && tail.payload.mem_read && (tail.payload.rd_addr == rf_rs1_addr_o)) begin
        hazard = 1'b1;
      end
    end
    if (dec.uses_rs2 && (rf_rs2_addr_o != 5'd0)) begin
      if (ex_mem_read_i && (ex_rd_addr_i == rf_rs2_addr_o)) hazard = 1'b1;
      if (id_valid_o && tail.payload.mem_read && (tail.payload.rd_addr == rf_rs2_addr_o)) begin
        hazard = 1'b1;
      end
    end
  end
  logic unused_sink;
  assign unused_sink = ^tail;
`else
  assign hazard = 1'b0;
  logic unused_sink;
  assign unused_sink = ^{tail, dec, ex_mem_read_i, ex_rd_addr_i};
`endif

  // Ready never depends on id_ready_i, so EX backpressure has no comb path to fetch.
  assign if_ready_o = ~full & ~hazard & (state_q == StRun);
  assign push       = if_valid_i & if_ready_o & ~flush_i & (~entry_in.illegal | TRAP_ILLEGAL);
  assign id_valid_o = (count != '0);
  assign pop        = id_valid_o & id_ready_i;

  // Enter trap once an illegal word is queued; only a redirect resumes fetch.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StRun;
    end else if (push && entry_in.illegal) begin
      state_d = StTrap;
    end
  end

  // Stage state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  rv32i_id_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(flush_i),
    .push_i (push),
    .pop_i  (pop),
    .data_i (entry_in),
    .head_o (head),
    .tail_o (tail),
    .count_o(count),
    .full_o (full)
  );

  assign id_payload_o       = head.payload;
  assign id_illegal_o       = id_valid_o & head.illegal;
  assign id_illegal_instr_o = head.instr;

endmodule

// File: tb/tb_rv32i_id_pipe.sv
// Scoreboard bench for rv32i_id_pipe (DEPTH=2, TRAP_ILLEGAL=1). Expected entries
// are queued when a word is offered and accepted, and popped on each EX dequeue.
module tb_rv32i_id_pipe;
  import rv32i_core_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           if_valid_i;
  if_id_payload_t if_payload_i;
  logic           if_ready_o;
  logic           id_valid_o;
  id_ex_payload_t id_payload_o;
  logic           id_ready_i;
  logic           id_illegal_o;
  logic [31:0]    id_illegal_instr_o;
  logic [4:0]     rf_rs1_addr_o, rf_rs2_addr_o;
  logic [31:0]    rf_rs1_data_i, rf_rs2_data_i;
  logic           flush_i;
  logic           ex_mem_read_i;
  logic [4:0]     ex_rd_addr_i;

  always #5 clk_i = ~clk_i;

  rv32i_id_pipe #(
    .DEPTH       (2),
    .TRAP_ILLEGAL(1'b1)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .if_valid_i        (if_valid_i),
    .if_payload_i      (if_payload_i),
    .if_ready_o        (if_ready_o),
    .id_valid_o        (id_valid_o),
    .id_payload_o      (id_payload_o),
    .id_ready_i        (id_ready_i),
    .id_illegal_o      (id_illegal_o),
    .id_illegal_instr_o(id_illegal_instr_o),
    .rf_rs1_addr_o     (rf_rs1_addr_o),
    .rf_rs2_addr_o     (rf_rs2_addr_o),
    .rf_rs1_data_i     (rf_rs1_data_i),
    .rf_rs2_data_i     (rf_rs2_data_i),
    .flush_i           (flush_i),
    .ex_mem_read_i     (ex_mem_read_i),
    .ex_rd_addr_i      (ex_rd_addr_i)
  );

  typedef struct {
    logic [31:0] pc, instr, pc4, imm, rs1d, rs2d;
    logic [4:0]  rd;
    logic [4:0]  flags;  // {reg_write, mem_read, mem_write, branch, jump}
    logic        ill;
  } exp_t;

  exp_t tbl [8];
  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return 32'hA5A5_0000 ^ {22'b0, a, a};
  endfunction

  assign rf_rs1_data_i = rf_val(rf_rs1_addr_o);
  assign rf_rs2_data_i = rf_val(rf_rs2_addr_o);

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] imm, input logic [4:0] flags, input logic ill);
    exp_t e;
    e.pc = pc; e.instr = instr; e.pc4 = pc + 32'd4; e.imm = imm;
    e.rd = instr[11:7]; e.rs1d = rf_val(instr[19:15]); e.rs2d = rf_val(instr[24:20]);
    e.flags = flags; e.ill = ill;
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // EX side: every dequeue must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_ni && id_valid_o && id_ready_i) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_deq", 32'(id_valid_o), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("deq_pc4", id_payload_o.pc_plus4, mon_e.pc4);
        check_eq("deq_flags", {27'b0, id_payload_o.reg_write, id_payload_o.mem_read,
                               id_payload_o.mem_write, id_payload_o.branch, id_payload_o.jump},
                 {27'b0, mon_e.flags});
        check_eq("deq_illegal", 32'(id_illegal_o), 32'(mon_e.ill));
        if (mon_e.ill) begin
          check_eq("deq_ill_instr", id_illegal_instr_o, mon_e.instr);
        end else begin
          check_eq("deq_imm", id_payload_o.imm, mon_e.imm);
          check_eq("deq_rd", 32'(id_payload_o.rd_addr), 32'(mon_e.rd));
          check_eq("deq_rs1d", id_payload_o.rs1_data, mon_e.rs1d);
          check_eq("deq_rs2d", id_payload_o.rs2_data, mon_e.rs2d);
        end
      end
    end
    if (rst_ni && flush_i) sb.delete();
  end

  // Drive one word for one cycle (called at posedge+1), check ready, record expectation.
  task automatic offer(input int idx, input logic exp_rdy);
    if_valid_i         = 1'b1;
    if_payload_i.pc    = tbl[idx].pc;
    if_payload_i.instr = tbl[idx].instr;
    @(negedge clk_i);
    check_eq($sformatf("rdy_w%0d", idx), 32'(if_ready_o), 32'(exp_rdy));
    if (exp_rdy && !flush_i) sb.push_back(tbl[idx]);
    @(posedge clk_i); #1;
    if_valid_i = 1'b0;
  endtask

  task automatic probe(input string tag, input logic exp_v, input logic exp_r);
    @(negedge clk_i);
    check_eq({tag, "_valid"}, 32'(id_valid_o), 32'(exp_v));
    check_eq({tag, "_ready"}, 32'(if_ready_o), 32'(exp_r));
    @(posedge clk_i); #1;
  endtask

  task automatic drain(input string tag);
    id_ready_i = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk_i); #1;
    end
    check_eq({tag, "_drained"}, 32'(sb.size()), 32'd0);
    probe({tag, "_idle"}, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(32'h0000_0100, 32'h0050_0093, 32'd5,         5'b10000, 1'b0);  // addi x1,x0,5
    tbl[1] = mk(32'h0000_0200, 32'h0081_2283, 32'd8,         5'b11000, 1'b0);  // lw x5,8(x2)
    tbl[2] = mk(32'h0000_0204, 32'h0012_8333, 32'd0,         5'b10000, 1'b0);  // add x6,x5,x1
    tbl[3] = mk(32'h0000_0208, 32'hFE31_2E23, 32'hFFFF_FFFC, 5'b00100, 1'b0);  // sw x3,-4(x2)
    tbl[4] = mk(32'h0000_020C, 32'h0020_8463, 32'd8,         5'b00010, 1'b0);  // beq x1,x2,+8
    tbl[5] = mk(32'h0000_0210, 32'h0100_00EF, 32'd16,        5'b10001, 1'b0);  // jal x1,+16
    tbl[6] = mk(32'h0000_0214, 32'h1234_53B7, 32'h1234_5000, 5'b10000, 1'b0);  // lui x7,0x12345
    tbl[7] = mk(32'h0000_0218, 32'hFFFF_FFFF, 32'd0,         5'b00000, 1'b1);  // illegal

    if_valid_i = 1'b0; if_payload_i = '0; id_ready_i = 1'b0;
    flush_i = 1'b0; ex_mem_read_i = 1'b0; ex_rd_addr_i = '0;

    // Reset values, then ready in the first cycle after release.
    #12;
    check_eq("rst_valid", 32'(id_valid_o), 32'd0);
    check_eq("rst_illegal", 32'(id_illegal_o), 32'd0);
    check_eq("rst_payload_or", 32'(|id_payload_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    probe("post_rst", 1'b0, 1'b1);

    // Single ADDI at 0x100: valid with latency 1.
    id_ready_i = 1'b1;
    offer(0, 1'b1);
    probe("lat1", 1'b1, 1'b1);
    drain("single");

    // Back-to-back stream with same-cycle enqueue/dequeue.
    id_ready_i = 1'b1;
    offer(0, 1'b1); offer(3, 1'b1); offer(4, 1'b1); offer(5, 1'b1); offer(6, 1'b1); offer(1, 1'b1);
    drain("stream");

    // Fill to DEPTH under backpressure; third word refused, head held stable.
    id_ready_i = 1'b0;
    offer(3, 1'b1); offer(4, 1'b1); offer(6, 1'b0);
    @(negedge clk_i); check_eq("hold_a", id_payload_o.pc_plus4, tbl[3].pc4);
    @(posedge clk_i); #1;
    probe("full", 1'b1, 1'b0);
    @(negedge clk_i); check_eq("hold_b", id_payload_o.pc_plus4, tbl[3].pc4);
    @(posedge clk_i); #1;
    drain("fill");

    // Load-use: LW x5 buffered, then ADD x6,x5,x1.
    id_ready_i = 1'b0;
    offer(1, 1'b1);
`ifdef RV32I_LOAD_USE_STALL_EN
    offer(2, 1'b0);
    id_ready_i = 1'b1; ex_mem_read_i = 1'b1; ex_rd_addr_i = 5'd5;
    offer(2, 1'b0);
    offer(2, 1'b0);
    ex_mem_read_i = 1'b0;
    offer(2, 1'b1);
`else
    offer(2, 1'b1);
`endif
    drain("loaduse");

    // Flush with a full buffer and a same-cycle incoming word.
    id_ready_i = 1'b0;
    offer(0, 1'b1); offer(3, 1'b1);
    flush_i = 1'b1;
    offer(4, 1'b0);
    flush_i = 1'b0;
    probe("flush_full", 1'b0, 1'b1);
    // Flush discards an accepted same-cycle enqueue.
    offer(0, 1'b1);
    flush_i = 1'b1;
    offer(3, 1'b1);
    flush_i = 1'b0;
    probe("flush_enq", 1'b0, 1'b1);
    // Flush coincident with a dequeue: the dequeue still completes.
    id_ready_i = 1'b1;
    offer(5, 1'b1);
    flush_i = 1'b1;
    probe("flush_deq", 1'b1, 1'b1);
    flush_i = 1'b0;
    probe("after_flush_deq", 1'b0, 1'b1);

    // Illegal word traps until flush.
    id_ready_i = 1'b0;
    offer(7, 1'b1);
    @(negedge clk_i);
    check_eq("ill_flag", 32'(id_illegal_o), 32'd1);
    check_eq("ill_instr", id_illegal_instr_o, 32'hFFFF_FFFF);
    check_eq("ill_rw", 32'(id_payload_o.reg_write), 32'd0);
    check_eq("ill_rdy", 32'(if_ready_o), 32'd0);
    @(posedge clk_i); #1;
    offer(0, 1'b0);
    flush_i = 1'b1;
    offer(0, 1'b0);
    flush_i = 1'b0;
    offer(0, 1'b1);
    drain("trap");

    // Asynchronous reset mid-stream with two entries buffered.
    id_ready_i = 1'b0;
    offer(0, 1'b1); offer(3, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("arst_valid", 32'(id_valid_o), 32'd0);
    check_eq("arst_illegal", 32'(id_illegal_o), 32'd0);
    check_eq("arst_payload_or", 32'(|id_payload_o), 32'd0);
    sb.delete();
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    id_ready_i = 1'b1;
    offer(6, 1'b1);
    probe("arst_lat1", 1'b1, 1'b1);
    drain("arst");

    check_eq("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_id_pipe.md
RV32I_ID_PIPE -- requirements
Module: rv32i_id_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of ID/EX payload entries buffered (legal 1..4).
REQ-002 SHALL have parameter TRAP_ILLEGAL, default 1; when 1, illegal instructions are trapped, and when 0 they are dropped silently.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port if_valid_i / if_payload_i (if_id_payload_t), input; fetch handshake data.
REQ-006 SHALL have port if_ready_o, output, 1; the stage accepts the fetch word this cycle.
REQ-007 SHALL have ports id_valid_o, output, 1; id_payload_o (id_ex_payload_t), output; id_ready_i, input, 1; these form the EX handshake.
REQ-008 SHALL have ports id_illegal_o, output, 1, and id_illegal_instr_o, output, 32; these mark the head entry as illegal and carry its encoding.
REQ-009 SHALL have ports rf_rs1_addr_o / rf_rs2_addr_o, output, 5, and rf_rs1_data_i / rf_rs2_data_i, input, 32; these form the register-file read.
REQ-010 SHALL have port flush_i, input, 1; a redirect that discards all buffered work.
REQ-011 SHALL have ports ex_mem_read_i, input, 1, and ex_rd_addr_i, input, 5; these carry the EX-stage load destination.

Function
REQ-012 SHALL decode if_payload_i combinationally (rv32i_decoder, rv32i_imm_gen) and build the payload exactly as the single-cycle decode does, with pc_plus4 = pc + 4 modulo 2^32.
REQ-013 SHALL enqueue the decoded payload and RF data on the cycle when if_valid_i && if_ready_o; id_valid_o rises the next cycle (latency 1 when empty).
REQ-014 SHALL drive if_ready_o = !full && !hazard && state==RUN, with no combinational path from id_ready_i.
REQ-015 SHALL present the head entry on id_payload_o while id_valid_o = (count != 0), and dequeue it on id_valid_o && id_ready_i.
REQ-016 SHALL allow enqueue and dequeue in the same cycle, leaving count unchanged; read and write pointers wrap from DEPTH-1 to 0.
REQ-017 SHALL hold id_payload_o stable while id_valid_o && !id_ready_i.
REQ-018 SHALL implement two states. RUN: normal operation. TRAP: entered when an illegal word is enqueued (TRAP_ILLEGAL=1); accepts stop, and the state is left only via flush_i.
REQ-019 SHALL enqueue an illegal entry with reg_write, mem_write, mem_read, branch and jump forced to 0; id_illegal_o is asserted while that entry is head.
REQ-020 with TRAP_ILLEGAL=0, SHALL accept an illegal word (if_ready_o=1) but not enqueue it.
REQ-021 on flush_i, SHALL clear count and both pointers at the next edge, discard any same-cycle enqueue, return to RUN, and deassert id_valid_o the following cycle.
REQ-022 SHALL ignore flush_i coincident with a dequeue; the dequeue still completes toward EX.
REQ-023 SHALL never produce a simulation $fatal for illegal instructions.

Reset
REQ-024 while rst_ni=0, SHALL set state=RUN, count=0, pointers=0, id_valid_o=0, id_illegal_o=0, and id_payload_o='0.
REQ-025 SHALL make if_ready_o=1 in the first cycle after reset release.

Configuration
REQ-026 with macro RV32I_LOAD_USE_STALL_EN defined, hazard=1 when the incoming instruction uses rs1 or rs2 (nonzero) equal to ex_rd_addr_i with ex_mem_read_i=1, or equal to rd of the newest buffered entry with mem_read=1.
REQ-027 without RV32I_LOAD_USE_STALL_EN, hazard SHALL be 0 and ex_mem_read_i / ex_rd_addr_i are unused.

Structure
REQ-028 SHALL place id_entry_t (id_ex_payload_t plus illegal bit plus raw instr) and a DEPTH-independent ID_PIPE_MAX_DEPTH=4 constant in rv32i_core_pkg.
REQ-029 SHALL use one sub-module, rv32i_id_fifo, a parametrised DEPTH buffer with count and pointer logic; decoder and imm_gen are reused unchanged.

Verification
REQ-030 Empty pipe, ADDI x1,x0,5 at PC 0x100, id_ready_i=1 -> id_valid_o next cycle, imm=5, rd=1, pc_plus4=0x104.
REQ-031 DEPTH=2, id_ready_i=0, three valid words -> first two accepted, if_ready_o=0 on the third; on id_ready_i=1 the entries drain in order.
REQ-032 Word 0xFFFFFFFF with TRAP_ILLEGAL=1 -> id_illegal_o=1 with id_illegal_instr_o=0xFFFFFFFF, reg_write=0, if_ready_o=0 until flush_i, then RUN.
REQ-033 LW x5 buffered, then ADD x6,x5,x1 with RV32I_LOAD_USE_STALL_EN -> if_ready_o=0 until the LW dequeues and leaves EX; without the macro it is accepted immediately.
REQ-034 Full buffer plus flush_i plus if_valid_i in the same cycle -> id_valid_o=0 next cycle and the incoming word is not enqueued.
REQ-035 rst_ni asserted mid-stream with count=2 -> all outputs at reset values asynchronously; first post-release word appears with latency 1.
